// File: rtl/keypad_display_decoder_if.sv
// Key strobe bus into the display decoder plus the exported MM:SS entry buffer.
interface keypad_display_decoder_if;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        lock;
  logic [15:0] digits;
  logic        ready;
  logic        err;

  modport master (output key_code, key_valid, lock, input digits, ready, err);
  modport slave  (input key_code, key_valid, lock, output digits, ready, err);
endinterface

// File: rtl/keypad_display_decoder.sv
// Four-digit MM:SS entry buffer fed by encoded key strobes, driving a scanned seven-segment display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero minute digits.
module keypad_display_decoder #(
  parameter int SCAN_DIV = 16
) (
  input  logic                           i_clk,
  input  logic                           i_clear,
  keypad_display_decoder_if.slave        key_bus,
  output logic [3:0]                     o_an,
  output logic [6:0]                     o_seg
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [15:0]      r_digits;
  logic [2:0]       r_count;
  logic             r_ready;
  logic             r_err;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_idx;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;

  logic             w_key_bad;
  logic [15:0]      w_digits_nxt;
  logic [2:0]       w_count_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic [1:0]       w_idx_nxt;
  logic [3:0]       w_nibble;
  logic             w_blank;
  logic [3:0]       w_an_nxt;
  logic [6:0]       w_seg_nxt;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h00;
    endcase
  endfunction

  // Key acceptance: shift valid digits in, flag invalid codes, ignore everything while locked.
  always_comb begin
    w_key_bad    = 1'b0;
    w_digits_nxt = r_digits;
    w_count_nxt  = r_count;
    if (key_bus.key_valid && !key_bus.lock) begin
      if (key_bus.key_code <= 4'd9) begin
        w_digits_nxt = {r_digits[11:0], key_bus.key_code};
        if (r_count != 3'd4) begin
          w_count_nxt = r_count + 3'd1;
        end else begin
          w_count_nxt = r_count;
        end
      end else begin
        w_key_bad = 1'b1;
      end
    end else begin
      w_key_bad = 1'b0;
    end
  end

  // Scan timing and display data; an/seg come from the next index and next buffer so they move together.
  always_comb begin
    w_div_nxt = r_div + DIV_W'(1);
    w_idx_nxt = r_idx;
    w_nibble  = 4'd0;
    w_blank   = 1'b0;
    if (r_div == DIV_LAST) begin
      w_div_nxt = '0;
      w_idx_nxt = r_idx + 2'd1;
    end else begin
      w_div_nxt = r_div + DIV_W'(1);
      w_idx_nxt = r_idx;
    end
    case (w_idx_nxt)
      2'd0:    w_nibble = w_digits_nxt[3:0];
      2'd1:    w_nibble = w_digits_nxt[7:4];
      2'd2:    w_nibble = w_digits_nxt[11:8];
      2'd3:    w_nibble = w_digits_nxt[15:12];
      default: w_nibble = 4'd0;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if (w_idx_nxt == 2'd3) begin
      w_blank = (w_digits_nxt[15:12] == 4'd0);
    end else if (w_idx_nxt == 2'd2) begin
      w_blank = (w_digits_nxt[15:8] == 8'd0);
    end else begin
      w_blank = 1'b0;
    end
`else
    w_blank = 1'b0;
`endif
    w_an_nxt  = 4'b0001 << w_idx_nxt;
    w_seg_nxt = w_blank ? 7'h00 : glyph(w_nibble);
  end

  // State registers; clear overrides any simultaneous key strobe.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_digits <= 16'h0000;
      r_count  <= 3'd0;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
      r_div    <= '0;
      r_idx    <= 2'd0;
      r_an     <= 4'b0001;
      r_seg    <= 7'h3F;
    end else begin
      r_digits <= w_digits_nxt;
      r_count  <= w_count_nxt;
      r_ready  <= (w_count_nxt != 3'd0);
      r_err    <= w_key_bad;
      r_div    <= w_div_nxt;
      r_idx    <= w_idx_nxt;
      r_an     <= w_an_nxt;
      r_seg    <= w_seg_nxt;
    end
  end

  assign key_bus.digits = r_digits;
  assign key_bus.ready  = r_ready;
  assign key_bus.err    = r_err;
  assign o_an           = r_an;
  assign o_seg          = r_seg;
endmodule

// File: tb/tb_keypad_display_decoder.sv
// Scoreboard bench: stimulus pushes model expectations, a monitor pops and compares after each edge.
module tb_keypad_display_decoder;
  localparam int SD = 4;

  typedef struct {
    logic [15:0] digits;
    logic        ready;
    logic        err;
    logic [3:0]  an;
    logic [6:0]  seg;
  } exp_t;

  logic       clk;
  logic       i_clear;
  logic [3:0] o_an;
  logic [6:0] o_seg;

  keypad_display_decoder_if kb();

  keypad_display_decoder #(.SCAN_DIV(SD)) dut (
    .i_clk   (clk),
    .i_clear (i_clear),
    .key_bus (kb),
    .o_an    (o_an),
    .o_seg   (o_seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  logic [6:0] glyph_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Reference model: a list of four decimal digits (index 0 = s_ones), an entry count and elapsed cycles.
  int md[4];
  int mcount = 0;
  int mt = 0;
  bit merr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit clr, input bit v, input logic [3:0] code, input bit lk);
    exp_t e;
    int slot;
    if (clr) begin
      for (int i = 0; i < 4; i++) md[i] = 0;
      mcount = 0;
      merr = 1'b0;
      mt = 0;
    end else begin
      merr = 1'b0;
      if (v && !lk) begin
        if (code <= 4'd9) begin
          for (int i = 3; i > 0; i--) md[i] = md[i-1];
          md[0] = int'(code);
          if (mcount < 4) mcount++;
        end else begin
          merr = 1'b1;
        end
      end
      mt++;
    end
    slot = (mt / SD) % 4;
    e.digits = {4'(md[3]), 4'(md[2]), 4'(md[1]), 4'(md[0])};
    e.ready  = (mcount != 0);
    e.err    = merr;
    e.an     = 4'(1 << slot);
    e.seg    = glyph_tab[md[slot]];
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 3 && md[3] == 0) e.seg = 7'h00;
    if (slot == 2 && md[3] == 0 && md[2] == 0) e.seg = 7'h00;
`endif
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit clr, input bit v, input logic [3:0] code, input bit lk);
    @(negedge clk);
    i_clear      = clr;
    kb.key_valid = v;
    kb.key_code  = code;
    kb.lock      = lk;
    model_step(clr, v, code, lk);
  endtask

  task automatic key(input logic [3:0] code, input bit lk);
    drive(1'b0, 1'b1, code, lk);
    drive(1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  // Monitor: one expectation per clock edge, compared shortly after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("digits", 32'(kb.digits), 32'(mon_e.digits));
      check("ready",  32'(kb.ready),  32'(mon_e.ready));
      check("err",    32'(kb.err),    32'(mon_e.err));
      check("an",     32'(o_an),      32'(mon_e.an));
      check("seg",    32'(o_seg),     32'(mon_e.seg));
    end
  end

  initial begin
    i_clear      = 1'b1;
    kb.key_valid = 1'b0;
    kb.key_code  = 4'd0;
    kb.lock      = 1'b0;

    drive(1'b1, 1'b0, 4'd0, 1'b0);
    drive(1'b1, 1'b0, 4'd0, 1'b0);

    key(4'd1, 1'b0);
    key(4'd2, 1'b0);
    key(4'd3, 1'b0);
    key(4'd0, 1'b0);
    key(4'd5, 1'b0);
    key(4'd12, 1'b0);
    key(4'd15, 1'b0);
    key(4'd7, 1'b1);
    key(4'd13, 1'b1);

    // Scan frame with 09:30 in the buffer.
    drive(1'b1, 1'b0, 4'd0, 1'b0);
    key(4'd0, 1'b0);
    key(4'd9, 1'b0);
    key(4'd3, 1'b0);
    key(4'd0, 1'b0);
    for (int i = 0; i < 4 * SD + 3; i++) drive(1'b0, 1'b0, 4'd0, 1'b0);

    // Clear colliding with a key strobe, then clear in the middle of a scan slot.
    drive(1'b1, 1'b1, 4'd8, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < SD + 2; i++) drive(1'b0, 1'b0, 4'd0, 1'b0);
    drive(1'b1, 1'b0, 4'd0, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
    end

    drive(1'b0, 1'b0, 4'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/keypad_display_decoder.md
# keypad_display_decoder

Receiving end of the keypad encoder path in the microwave controller. Accepts debounced, encoded key strobes (BCD digit plus one-cycle valid), shifts them into a four-digit MM:SS entry buffer, and drives a time-multiplexed four-digit seven-segment display from that buffer. Sits between the encoder/debounce stage and the front-panel display. Also exports the buffer to the cook-time logic.

## Interface

- `SCAN_DIV`, default 16: clock cycles each digit stays lit. Legal range ≥ 2.
- One clock; reset is synchronous and active-high.
- `clk`  in  1  system clock; all state changes on rising edge.
- `clear`  in  1  synchronous active-high reset; overrides every other input.
- `key_code`  in  4  encoded key value. 0–9 are digits; 10–15 are invalid.
- `key_valid`  in  1  one-cycle strobe qualifying `key_code`.
- `lock`  in  1  when high, key strobes are ignored (cooking in progress).
- `digits`  out  16  BCD buffer {m_tens, m_ones, s_tens, s_ones}; s_ones in [3:0].
- `ready`  out  1  high when at least one digit has been entered since reset.
- `err`  out  1  one-cycle pulse for an invalid code accepted while unlocked.
- `an`  out  4  one-hot digit enable, active high. an[0] = s_ones … an[3] = m_tens.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active high.

## Operation

- **Reset values** (`clear` = 1 at an edge):
  - `digits` = 0, internal digit count = 0, `ready` = 0, `err` = 0.
  - Scan divider = 0, scan index = 0, `an` = 4'b0001, `seg` = 7'h3F (glyph "0").
- **Digit entry**, on an edge with `key_valid` = 1, `lock` = 0, `key_code` ≤ 9:
  - `digits` ← {digits[11:0], key_code}.
  - Count increments, saturating at 4.
  - After 4 digits, further entries keep shifting; the oldest digit (m_tens) is discarded.
- **Invalid code**, with `key_valid` = 1, `lock` = 0, `key_code` ≥ 10:
  - `digits` and count unchanged; `err` = 1 for exactly one cycle.
- **Locked**: with `lock` = 1, `key_valid` is ignored entirely. No shift, no `err`.
- `ready` = (count ≠ 0), registered.
- No range check on entered values: 99:99 is legal here. Clamping belongs to the cook-time logic.
- **Scan divider**: counts 0 … SCAN_DIV−1. On reaching SCAN_DIV−1 it wraps to 0 and the scan index advances 0→1→2→3→0.
- **Segment decode** (seg hex): 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F.
  - Buffer nibbles are always 0–9 by construction.

## Timing

- Key strobe at edge n: `digits`, `ready` and `err` reflect it after edge n.
- `an` and `seg` are registered from the current scan index and buffer.
  - On index change, `an` and `seg` update together at the same edge, so there is no mismatch cycle.
  - A `digits` change shows on `seg` no later than one cycle after `digits` updates, if that digit is currently selected.
- Each `an` value is held exactly SCAN_DIV cycles; the full frame is 4·SCAN_DIV cycles.
- `clear` together with `key_valid`: `clear` wins and the key is lost.
- `clear` mid-scan restarts at index 0 on the next edge.
- Scanning is unaffected by `lock`, `key_valid` and `err`.

## Configuration

- Macro `LEADING_ZERO_BLANK_EN`.
- **Defined**: while m_tens is selected and m_tens = 0, `seg` = 0. While m_ones is selected and m_tens = m_ones = 0, `seg` = 0. Seconds digits are never blanked, and `an` still scans normally.
- **Undefined**: all four digits always display their glyph, including leading zeros.
- Reset `seg` is 7'h3F in both builds, because index 0 is s_ones.

## Test plan

- **Reset**: assert `clear` 2 cycles → `digits` = 0, `ready` = 0, `err` = 0, `an` = 0001, `seg` = 3F.
- **Entry**: strobe keys 1, 2, 3, 0 → `digits` = 16'h1230, `ready` = 1. A fifth key 5 → 16'h2305.
- **Invalid and lock**: strobe code 12 → one-cycle `err`, `digits` unchanged. Raise `lock` and strobe 7 → no change, no `err`.
- **Scan** (SCAN_DIV = 4, digits = 16'h0930): `an` cycles 0001, 0010, 0100, 1000 with 4 cycles each. `seg` = 3F, 4F, 6F, 3F; with `LEADING_ZERO_BLANK_EN`, the m_tens slot shows 00.
- **Collisions**: `clear` and `key_valid` high in the same cycle → `digits` = 0, count = 0. `clear` in the middle of a scan slot → `an` = 0001 on the next edge.
